// File: rtl/l2_status_regs_pkg.sv
// Shared constants and types for the L2 status register block:
// default geometry, flush FSM state encoding and a small popcount helper.
package l2_status_regs_pkg;

   localparam int unsigned L2_N_MSHR_DEFAULT = 16;
   localparam int unsigned L2_N_SETS_DEFAULT = 256;
   localparam int unsigned L2_N_WAYS_DEFAULT = 16;
   localparam int unsigned L2_N_FREE_MAX     = 4;

   typedef enum logic [1:0] {
      FLUSH_IDLE = 2'd0,
      FLUSH_WALK = 2'd1,
      FLUSH_DONE = 2'd2
   } flush_state_e;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/l2_status_regs_if.sv
// Flush-walk control bundle: the requester drives start/step/abort,
// the status block returns the walk position and progress flags.
interface l2_status_regs_if import l2_status_regs_pkg::*; #(
   parameter int unsigned N_SETS   = L2_N_SETS_DEFAULT,
   parameter int unsigned N_WAYS   = L2_N_WAYS_DEFAULT,
   localparam int unsigned SET_BITS = $clog2(N_SETS),
   localparam int unsigned WAY_BITS = $clog2(N_WAYS)
) ();

   logic                flush_start;
   logic                flush_step;
   logic                flush_abort;
   logic [SET_BITS-1:0] flush_set;
   logic [WAY_BITS-1:0] flush_way;
   logic                flush_active;
   logic                flush_done;

   modport master (
      output flush_start,
      output flush_step,
      output flush_abort,
      input  flush_set,
      input  flush_way,
      input  flush_active,
      input  flush_done
   );

   modport slave (
      input  flush_start,
      input  flush_step,
      input  flush_abort,
      output flush_set,
      output flush_way,
      output flush_active,
      output flush_done
   );

endinterface

// File: rtl/l2_status_regs_flush_walker.sv
// Set/way flush walker: steps through every (set, way) pair on request,
// then pulses done for one cycle before returning to idle.
module l2_flush_walker import l2_status_regs_pkg::*; #(
   parameter int unsigned N_SETS   = L2_N_SETS_DEFAULT,
   parameter int unsigned N_WAYS   = L2_N_WAYS_DEFAULT,
   localparam int unsigned SET_BITS = $clog2(N_SETS),
   localparam int unsigned WAY_BITS = $clog2(N_WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_start,
   input  logic                flush_step,
   input  logic                flush_abort,
   output logic [SET_BITS-1:0] flush_set,
   output logic [WAY_BITS-1:0] flush_way,
   output logic                flush_active,
   output logic                flush_done
);

   localparam logic [SET_BITS-1:0] SET_LAST = '1;
   localparam logic [WAY_BITS-1:0] WAY_LAST = '1;

   flush_state_e        state_q, state_d;
   logic [SET_BITS-1:0] set_q, set_d;
   logic [WAY_BITS-1:0] way_q, way_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FLUSH_IDLE;
         set_q   <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         way_q   <= way_d;
      end
   end

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      way_d   = way_q;
      if (flush_abort) begin
         state_d = FLUSH_IDLE;
         set_d   = '0;
         way_d   = '0;
      end else begin
         unique case (state_q)
            FLUSH_IDLE: begin
               if (flush_start) begin
                  state_d = FLUSH_WALK;
                  set_d   = '0;
                  way_d   = '0;
               end
            end
            FLUSH_WALK: begin
               if (flush_step) begin
                  // Last pair finishes the walk; counters stay at max in DONE.
                  if (way_q == WAY_LAST && set_q == SET_LAST) begin
                     state_d = FLUSH_DONE;
                  end else if (way_q == WAY_LAST) begin
                     way_d = '0;
                     set_d = set_q + SET_BITS'(1);
                  end else begin
                     way_d = way_q + WAY_BITS'(1);
                  end
               end
            end
            FLUSH_DONE: begin
               state_d = FLUSH_IDLE;
               set_d   = '0;
               way_d   = '0;
            end
            default: begin
               state_d = FLUSH_IDLE;
               set_d   = '0;
               way_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      flush_set    = set_q;
      flush_way    = way_q;
      flush_active = (state_q == FLUSH_WALK);
      flush_done   = (state_q == FLUSH_DONE);
   end

endmodule

// File: rtl/l2_status_regs.sv
// L2 status registers: MSHR free-entry counter with error tracking,
// generic set/clear flags, forward-stall tracking and the flush walker.
module l2_status_regs import l2_status_regs_pkg::*; #(
   parameter int unsigned N_MSHR    = L2_N_MSHR_DEFAULT,
   parameter int unsigned N_FREE    = 2,
   parameter int unsigned N_FLAGS   = 6,
   parameter int unsigned N_SETS    = L2_N_SETS_DEFAULT,
   parameter int unsigned N_WAYS    = L2_N_WAYS_DEFAULT,
   localparam int unsigned MSHR_BITS = $clog2(N_MSHR)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc_en,
   input  logic [N_FREE-1:0]           free_en,
   input  logic [N_FREE*MSHR_BITS-1:0] free_idx,
   input  logic [N_FLAGS-1:0]          flag_set,
   input  logic [N_FLAGS-1:0]          flag_clr,
   input  logic                        fwd_stall_set,
   input  logic [MSHR_BITS-1:0]        fwd_stall_idx,
   input  logic                        clr_fwd_stall_ended,
   l2_status_regs_if.slave             flush_bus,
   output logic [MSHR_BITS:0]          mshr_cnt,
   output logic                        mshr_full,
   output logic                        mshr_idle,
   output logic                        err_cnt,
   output logic [N_FLAGS-1:0]          flags,
   output logic [N_MSHR-1:0]           fwd_wait_mask,
   output logic                        fwd_stall,
   output logic                        fwd_stall_ended
);

   localparam int unsigned CNT_W = MSHR_BITS + 1;
   localparam int unsigned SUM_W = MSHR_BITS + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_MSHR);

   logic [CNT_W-1:0]     mshr_cnt_q, mshr_cnt_d;
   logic                 err_cnt_q, err_cnt_d;
   logic [N_FLAGS-1:0]   flags_q, flags_d;
   logic [N_MSHR-1:0]    fwd_wait_mask_q, fwd_wait_mask_d;
   logic                 fwd_stall_ended_q, fwd_stall_ended_d;

   logic [L2_N_FREE_MAX-1:0] free_en_pad;
   logic [2:0]               free_pop;
   logic [SUM_W-1:0]         cnt_sum;
   logic [MSHR_BITS-1:0]     rel_idx;
   logic                     stall_hit;

   always_comb begin
      free_en_pad = '0;
      free_en_pad[N_FREE-1:0] = free_en;
      free_pop   = popcount4(free_en_pad);
      cnt_sum    = SUM_W'(mshr_cnt_q) + SUM_W'(free_pop) - SUM_W'(alloc_en);
      mshr_cnt_d = mshr_cnt_q;
      err_cnt_d  = err_cnt_q;
      // Allocation with nothing free and nothing returning is dropped.
      if (alloc_en && mshr_cnt_q == '0 && free_pop == '0) begin
         err_cnt_d = 1'b1;
      end else if (cnt_sum > SUM_W'(N_MSHR)) begin
         mshr_cnt_d = CNT_MAX;
         err_cnt_d  = 1'b1;
      end else begin
         mshr_cnt_d = cnt_sum[CNT_W-1:0];
      end
   end

   always_comb begin
      flags_d = (flags_q | flag_set) & ~flag_clr;
   end

   always_comb begin
      fwd_wait_mask_d = fwd_wait_mask_q;
      stall_hit       = 1'b0;
      rel_idx         = '0;
      if (fwd_stall_set) begin
         fwd_wait_mask_d[fwd_stall_idx] = 1'b1;
      end
      // A release that matches a same-cycle stall request also counts as a hit.
      for (int unsigned p = 0; p < N_FREE; p++) begin
         rel_idx = free_idx[p*MSHR_BITS +: MSHR_BITS];
         if (free_en[p] &&
             (fwd_wait_mask_q[rel_idx] || (fwd_stall_set && fwd_stall_idx == rel_idx))) begin
            fwd_wait_mask_d[rel_idx] = 1'b0;
            stall_hit                = 1'b1;
         end
      end
      fwd_stall_ended_d = stall_hit | (fwd_stall_ended_q & ~clr_fwd_stall_ended);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mshr_cnt_q        <= CNT_MAX;
         err_cnt_q         <= 1'b0;
         flags_q           <= '0;
         fwd_wait_mask_q   <= '0;
         fwd_stall_ended_q <= 1'b0;
      end else begin
         mshr_cnt_q        <= mshr_cnt_d;
         err_cnt_q         <= err_cnt_d;
         flags_q           <= flags_d;
         fwd_wait_mask_q   <= fwd_wait_mask_d;
         fwd_stall_ended_q <= fwd_stall_ended_d;
      end
   end

   assign mshr_cnt        = mshr_cnt_q;
   assign mshr_full       = (mshr_cnt_q == '0);
   assign mshr_idle       = (mshr_cnt_q == CNT_MAX);
   assign err_cnt         = err_cnt_q;
   assign flags           = flags_q;
   assign fwd_wait_mask   = fwd_wait_mask_q;
   assign fwd_stall       = |fwd_wait_mask_q;
   assign fwd_stall_ended = fwd_stall_ended_q;

   l2_flush_walker #(
      .N_SETS (N_SETS),
      .N_WAYS (N_WAYS)
   ) u_flush_walker (
      .clk          (clk),
      .rst          (rst),
      .flush_start  (flush_bus.flush_start),
      .flush_step   (flush_bus.flush_step),
      .flush_abort  (flush_bus.flush_abort),
      .flush_set    (flush_bus.flush_set),
      .flush_way    (flush_bus.flush_way),
      .flush_active (flush_bus.flush_active),
      .flush_done   (flush_bus.flush_done)
   );

endmodule

// File: doc/l2_status_regs.md
L2_STATUS_REGS -- requirements
Module: l2_status_regs

Interface
REQ-001 SHALL take parameter N_MSHR, default 16: number of MSHR entries; must be a power of two, at least 2.
REQ-002 SHALL take parameter N_FREE, default 2: MSHR release ports per cycle, range 1..4.
REQ-003 SHALL take parameter N_FLAGS, default 6: number of generic set/clear status flags (evict stall, set conflict, fence, drain, atomic, flush).
REQ-004 SHALL take parameters N_SETS, default 256, and N_WAYS, default 16, for the flush walk; both must be powers of two.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock.
REQ-006 SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have the port alloc_en, input, 1 bit: allocate one MSHR entry this cycle.
REQ-008 SHALL have the port free_en, input, N_FREE bits: per-port release valid.
REQ-009 SHALL have the port free_idx, input, N_FREE*MSHR_BITS bits: released entry index per port.
REQ-010 SHALL have the ports flag_set and flag_clr, input, N_FLAGS bits each: per-flag set and clear triggers.
REQ-011 SHALL have the ports fwd_stall_set (input, 1 bit) and fwd_stall_idx (input, MSHR_BITS bits): mark entry fwd_stall_idx as blocking a forward.
REQ-012 SHALL have the port clr_fwd_stall_ended, input, 1 bit.
REQ-013 SHALL have the ports flush_start, flush_step and flush_abort, input, 1 bit each.
REQ-014 SHALL have the outputs mshr_cnt (MSHR_BITS+1 bits), mshr_full and mshr_idle (1 bit each), and err_cnt (1 bit, sticky).
REQ-015 SHALL have the outputs flags (N_FLAGS bits), fwd_wait_mask (N_MSHR bits), fwd_stall (1 bit) and fwd_stall_ended (1 bit).
REQ-016 SHALL have the outputs flush_set (SET_BITS bits), flush_way (WAY_BITS bits), flush_active (1 bit) and flush_done (1 bit).

Function
REQ-017 mshr_cnt SHALL count free entries and update each cycle to mshr_cnt - alloc_en + popcount(free_en); ports with duplicate indices each count once per port.
REQ-018 mshr_full SHALL equal (mshr_cnt==0), and mshr_idle SHALL equal (mshr_cnt==N_MSHR); both are combinational from the register.
REQ-019 An alloc_en while mshr_cnt==0 with no free_en active SHALL be ignored and SHALL set err_cnt.
REQ-020 A result above N_MSHR SHALL saturate mshr_cnt at N_MSHR and SHALL set err_cnt.
REQ-021 Each flags[i] SHALL be cleared by flag_clr[i], else set by flag_set[i], else held; clear wins when both are asserted.
REQ-022 fwd_stall_set SHALL set fwd_wait_mask[fwd_stall_idx] on the next edge.
REQ-023 Any free_en[p] whose free_idx[p] hits a set mask bit SHALL clear that bit and SHALL set fwd_stall_ended.
REQ-024 When fwd_stall_set and a matching release hit the same index in the same cycle, the release SHALL win: the bit stays 0 and fwd_stall_ended is set.
REQ-025 fwd_stall SHALL equal the OR-reduction of fwd_wait_mask.
REQ-026 fwd_stall_ended SHALL be sticky; clr_fwd_stall_ended SHALL clear it unless a hit occurs in the same cycle, in which case it stays 1.
REQ-027 The flush FSM SHALL have the states IDLE, WALK and DONE.
REQ-028 IDLE SHALL move to WALK on flush_start, with flush_set and flush_way cleared to 0.
REQ-029 In WALK, flush_step SHALL increment flush_way; when flush_way==N_WAYS-1 it SHALL wrap to 0 and increment flush_set.
REQ-030 A flush_step at the last set and last way SHALL move to DONE, with counters held at their maximum.
REQ-031 DONE SHALL assert flush_done for exactly one cycle and then move to IDLE.
REQ-032 flush_active SHALL be 1 in WALK only.
REQ-033 flush_abort SHALL force IDLE from any state with counters at 0 and no flush_done; it has priority over flush_step.
REQ-034 flush_start outside IDLE SHALL be ignored.
REQ-035 All outputs SHALL be registered state or single-level decodes of registered state; there is no input-to-output combinational path.

Reset
REQ-036 Asserting rst SHALL asynchronously set: mshr_cnt=N_MSHR, flags=0, fwd_wait_mask=0, fwd_stall_ended=0, err_cnt=0, FSM=IDLE, flush_set=0, flush_way=0.
REQ-037 Reset mid-walk SHALL abandon the walk without a flush_done pulse.

Structure
REQ-038 The FSM state enum and the default values of N_MSHR, N_SETS and N_WAYS SHALL live in the shared spandex consts/types package.
REQ-039 MSHR_BITS, SET_BITS and WAY_BITS SHALL be derived locally with $clog2.
REQ-040 The flush walker SHALL be a sub-module, l2_flush_walker.

Verification
REQ-041 Reset, then alloc_en for 16 cycles -> mshr_cnt=0 and mshr_full=1; a 17th alloc_en -> mshr_cnt stays 0 and err_cnt=1.
REQ-042 From mshr_cnt=5: alloc_en with free_en=2'b11 in one cycle -> mshr_cnt=6.
REQ-043 fwd_stall_set at idx 3 and at idx 7, then free idx 3 -> mask=0x0080, fwd_stall=1, fwd_stall_ended=1; then clr_fwd_stall_ended with free idx 7 in the same cycle -> mask=0 and fwd_stall_ended remains 1.
REQ-044 flags: flag_set[2] and flag_clr[2] asserted together -> flags[2]=0; flag_set[2] alone -> flags[2]=1.
REQ-045 With N_SETS=4 and N_WAYS=2: flush_start then 8 flush_step -> (set,way) sequence 0,1 / 1,0 / ... / 3,1, then flush_done pulses for one cycle and the FSM returns to IDLE.
REQ-046 flush_abort and rst asserted mid-walk at set 2 -> IDLE, counters 0, flush_done never asserted.
